// File: rtl/ctrl_fsm_rv32i.sv
// ctrl_fsm_rv32i -- multi-cycle RV32I control unit.
//
// Sequences one instruction at a time through fetch handshake, decode,
// execute, optional data-memory access and register write-back. It also
// produces the ALU/datapath control words and the write strobes.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   instr_valid/instr/instr_ready  fetch handshake (accept on valid & ready)
//   br_taken                       external branch comparator result
//   mem_ready                      data memory completion
//   cu_*                           registered ALU control fields
//   sel_in1/sel_in2                registered ALU operand selects
//   wb_sel, pc_sel                 write-back / next-PC selects
//   reg_we, mem_re, mem_we, pc_we  single-cycle commit strobes
//   trap, trap_cause               trap status (01 illegal, 10 mem timeout)
//
// state  | meaning
// FETCH  | instr_ready high, wait for instr_valid
// DECODE | check opcode, compute control word
// EXEC   | ALU cycle; branches resolve and commit PC here
// MEM    | hold mem_re/mem_we until mem_ready or timeout
// WB     | register write-back and PC update
// TRAP   | absorbing error state, left only by reset

module ctrl_fsm_rv32i #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic [1:0]  cu_ALUtype,
    output logic        cu_adtype,
    output logic [1:0]  cu_gatype,
    output logic [1:0]  cu_shiftype,
    output logic        cu_sltype,
    output logic [1:0]  sel_in1,
    output logic        sel_in2,
    output logic [1:0]  wb_sel,
    output logic        pc_sel,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        pc_we,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    // Counter value during the MEM_TIMEOUT-th wait cycle (counter starts at 0).
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
    logic [1:0]      alu_type_q, alu_type_d;
    logic            ad_type_q, ad_type_d;
    logic [1:0]      ga_type_q, ga_type_d;
    logic [1:0]      sh_type_q, sh_type_d;
    logic            sl_type_q, sl_type_d;
    logic [1:0]      sel_in1_q, sel_in1_d;
    logic            sel_in2_q, sel_in2_d;
    logic            legal, load_instr, load_ctrl, ready_c;

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       alt;
    logic       is_load, is_store, is_branch, is_jump;
    logic       unused_instr;

    assign opc       = instr_q[6:0];
    assign funct3    = instr_q[14:12];
    assign alt       = instr_q[30];
    assign is_load   = (opc == OPC_LOAD);
    assign is_store  = (opc == OPC_STORE);
    assign is_branch = (opc == OPC_BRANCH);
    assign is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);
    assign unused_instr = ^{instr_q[31], instr_q[29:15], instr_q[11:7]};

    // Control word decode from the latched instruction.
    always_comb begin
        legal      = 1'b1;
        alu_type_d = 2'b00;
        ad_type_d  = 1'b0;
        ga_type_d  = 2'b00;
        sh_type_d  = 2'b00;
        sl_type_d  = 1'b0;
        sel_in1_d  = 2'b00;
        sel_in2_d  = 1'b1;
        case (opc)
            OPC_OP, OPC_OPIMM: begin
                sel_in2_d = (opc == OPC_OPIMM);
                case (funct3)
                    3'b000: ad_type_d = (opc == OPC_OP) && alt;
                    3'b001: alu_type_d = 2'b10;
                    3'b010: alu_type_d = 2'b11;
                    3'b011: begin alu_type_d = 2'b11; sl_type_d = 1'b1; end
                    3'b100: begin alu_type_d = 2'b01; ga_type_d = 2'b10; end
                    3'b101: begin alu_type_d = 2'b10; sh_type_d = alt ? 2'b10 : 2'b01; end
                    3'b110: begin alu_type_d = 2'b01; ga_type_d = 2'b01; end
                    default: alu_type_d = 2'b01;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: sel_in1_d = 2'b00;
            OPC_BRANCH, OPC_JAL, OPC_AUIPC: sel_in1_d = 2'b01;
            OPC_LUI: sel_in1_d = 2'b10;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        load_instr = 1'b0;
        load_ctrl  = 1'b0;
        ready_c    = 1'b0;
        reg_we     = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        wb_sel     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ready_c = 1'b1;
                if (instr_valid) begin
                    load_instr = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    cause_d = 2'b01;
                    state_d = S_TRAP;
                end else begin
                    load_ctrl = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load || is_store) begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else if (is_branch) begin
                    pc_we   = 1'b1;
                    pc_sel  = br_taken;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_re = is_load;
                mem_we = is_store;
                // Completion takes priority over the timeout in the last wait cycle.
                if (mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB: begin
                reg_we  = !(is_store || is_branch);
                wb_sel  = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                pc_we   = 1'b1;
                pc_sel  = is_jump;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            instr_q    <= '0;
            cnt_q      <= '0;
            cause_q    <= '0;
            alu_type_q <= '0;
            ad_type_q  <= 1'b0;
            ga_type_q  <= '0;
            sh_type_q  <= '0;
            sl_type_q  <= 1'b0;
            sel_in1_q  <= '0;
            sel_in2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            if (load_instr) instr_q <= instr;
            if (load_ctrl) begin
                alu_type_q <= alu_type_d;
                ad_type_q  <= ad_type_d;
                ga_type_q  <= ga_type_d;
                sh_type_q  <= sh_type_d;
                sl_type_q  <= sl_type_d;
                sel_in1_q  <= sel_in1_d;
                sel_in2_q  <= sel_in2_d;
            end
        end
    end

    // Gated by rst_n so instr_ready is low while reset is held.
    assign instr_ready = ready_c & rst_n;
    assign trap        = (state_q == S_TRAP);
    assign trap_cause  = cause_q;
    assign cu_ALUtype  = alu_type_q;
    assign cu_adtype   = ad_type_q;
    assign cu_gatype   = ga_type_q;
    assign cu_shiftype = sh_type_q;
    assign cu_sltype   = sl_type_q;
    assign sel_in1     = sel_in1_q;
    assign sel_in2     = sel_in2_q;

endmodule

// File: tb/tb_ctrl_fsm_rv32i.sv
// tb_ctrl_fsm_rv32i -- self-checking bench for ctrl_fsm_rv32i.
// Expected behaviour per instruction is built as a cycle-by-cycle list from
// the instruction's semantics, then the DUT is driven and compared.

module tb_ctrl_fsm_rv32i;

    localparam int TO = 15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        instr_ready;
    logic [1:0]  cu_ALUtype;
    logic        cu_adtype;
    logic [1:0]  cu_gatype;
    logic [1:0]  cu_shiftype;
    logic        cu_sltype;
    logic [1:0]  sel_in1;
    logic        sel_in2;
    logic [1:0]  wb_sel;
    logic        pc_sel;
    logic        reg_we, mem_re, mem_we, pc_we, trap;
    logic [1:0]  trap_cause;

    int tests_run = 0;
    int tests_failed = 0;

    ctrl_fsm_rv32i #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .br_taken(br_taken), .mem_ready(mem_ready),
        .cu_ALUtype(cu_ALUtype), .cu_adtype(cu_adtype), .cu_gatype(cu_gatype),
        .cu_shiftype(cu_shiftype), .cu_sltype(cu_sltype),
        .sel_in1(sel_in1), .sel_in2(sel_in2), .wb_sel(wb_sel), .pc_sel(pc_sel),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .pc_we(pc_we),
        .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [6:0] o);
        return o inside {OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
    endfunction

    // {trap, ready, reg_we, mem_re, mem_we, pc_we, pc_sel, wb_sel, trap_cause}
    function automatic logic [10:0] pk(input logic t, input logic r, input logic rw,
                                       input logic mr, input logic mw, input logic pw,
                                       input logic ps, input logic [1:0] wb,
                                       input logic [1:0] c);
        return {t, r, rw, mr, mw, pw, ps, wb, c};
    endfunction

    function automatic logic [10:0] obs_vec();
        return {trap, instr_ready, reg_we, mem_re, mem_we, pc_we, pc_sel, wb_sel, trap_cause};
    endfunction

    function automatic logic [21:0] all_outs();
        return {instr_ready, cu_ALUtype, cu_adtype, cu_gatype, cu_shiftype, cu_sltype,
                sel_in1, sel_in2, wb_sel, pc_sel, reg_we, mem_re, mem_we, pc_we,
                trap, trap_cause};
    endfunction

    // Reference: instruction -> operation -> required ALU fields (masked to the
    // fields that matter for that operation) and operand sources.
    task automatic alu_model(input logic [31:0] ins, output logic [7:0] val,
                             output logic [7:0] msk, output logic [2:0] sel);
        logic [6:0] o;
        logic [2:0] f3;
        string op;
        o  = ins[6:0];
        f3 = ins[14:12];
        op = "add";
        if (o == OPC_OP || o == OPC_OPIMM) begin
            case (f3)
                3'd0: op = (o == OPC_OP && ins[30]) ? "sub" : "add";
                3'd1: op = "sll";
                3'd2: op = "slt";
                3'd3: op = "sltu";
                3'd4: op = "xor";
                3'd5: op = ins[30] ? "sra" : "srl";
                3'd6: op = "or";
                default: op = "and";
            endcase
        end
        // bits: [7:6] ALUtype, [5] adtype, [4:3] gatype, [2:1] shiftype, [0] sltype
        case (op)
            "add":  begin val = 8'b00_0_00_00_0; msk = 8'b1110_0000; end
            "sub":  begin val = 8'b00_1_00_00_0; msk = 8'b1110_0000; end
            "sll":  begin val = 8'b10_0_00_00_0; msk = 8'b1100_0110; end
            "srl":  begin val = 8'b10_0_00_01_0; msk = 8'b1100_0110; end
            "sra":  begin val = 8'b10_0_00_10_0; msk = 8'b1100_0110; end
            "slt":  begin val = 8'b11_0_00_00_0; msk = 8'b1100_0001; end
            "sltu": begin val = 8'b11_0_00_00_1; msk = 8'b1100_0001; end
            "xor":  begin val = 8'b01_0_10_00_0; msk = 8'b1101_1000; end
            "or":   begin val = 8'b01_0_01_00_0; msk = 8'b1101_1000; end
            default:begin val = 8'b01_0_00_00_0; msk = 8'b1101_1000; end
        endcase
        // {sel_in1, sel_in2}
        if (o == OPC_OP) sel = 3'b00_0;
        else if (o == OPC_BRANCH || o == OPC_JAL || o == OPC_AUIPC) sel = 3'b01_1;
        else if (o == OPC_LUI) sel = 3'b10_1;
        else sel = 3'b00_1;
    endtask

    // Drives one instruction from its accept cycle through the next FETCH
    // (or a few TRAP cycles). ready_at: MEM cycle (1-based) with mem_ready, 0 = never.
    task automatic run_instr(input logic [31:0] ins, input logic bt, input int ready_at,
                             input string name);
        logic [10:0] exp_q[$];
        logic        mr_q[$];
        logic        chk_q[$];
        logic [6:0]  o;
        logic [7:0]  val, msk, alu_o;
        logic [2:0]  sel;
        logic        ld, st, done;
        o  = ins[6:0];
        ld = (o == OPC_LOAD);
        st = (o == OPC_STORE);
        alu_model(ins, val, msk, sel);
        exp_q.push_back(pk(0,1,0,0,0,0,0,2'b00,2'b00)); mr_q.push_back(0); chk_q.push_back(0);
        exp_q.push_back(pk(0,0,0,0,0,0,0,2'b00,2'b00)); mr_q.push_back(0); chk_q.push_back(0);
        if (!is_legal(o)) begin
            repeat (3) begin
                exp_q.push_back(pk(1,0,0,0,0,0,0,2'b00,2'b01)); mr_q.push_back(0); chk_q.push_back(0);
            end
        end else begin
            done = 1'b1;
            if (o == OPC_BRANCH)
                exp_q.push_back(pk(0,0,0,0,0,1,bt,2'b00,2'b00));
            else
                exp_q.push_back(pk(0,0,0,0,0,0,0,2'b00,2'b00));
            mr_q.push_back(0); chk_q.push_back(1);
            if (ld || st) begin
                done = 1'b0;
                for (int k = 1; k <= TO; k++) begin
                    exp_q.push_back(pk(0,0,0,ld,st,st && k == ready_at,0,2'b00,2'b00));
                    mr_q.push_back(k == ready_at); chk_q.push_back(1);
                    if (k == ready_at) begin done = 1'b1; break; end
                end
                if (!done) begin
                    repeat (3) begin
                        exp_q.push_back(pk(1,0,0,0,0,0,0,2'b00,2'b10)); mr_q.push_back(0); chk_q.push_back(1);
                    end
                end
            end
            if (done && !st && o != OPC_BRANCH) begin
                exp_q.push_back(pk(0,0,1,0,0,1,(o == OPC_JAL || o == OPC_JALR),
                                   ld ? 2'b01 : ((o == OPC_JAL || o == OPC_JALR) ? 2'b10 : 2'b00),
                                   2'b00));
                mr_q.push_back(0); chk_q.push_back(1);
            end
            if (done) begin
                exp_q.push_back(pk(0,1,0,0,0,0,0,2'b00,2'b00)); mr_q.push_back(0); chk_q.push_back(1);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            instr_valid = (i == 0);
            instr       = ins;
            br_taken    = bt;
            mem_ready   = mr_q[i];
            #1;
            tests_run++;
            if (obs_vec() !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s cyc%0d strobes {trap,rdy,rwe,mre,mwe,pwe,psel,wb,cause} got %b want %b",
                         name, i, obs_vec(), exp_q[i]);
            end
            if (chk_q[i]) begin
                alu_o = {cu_ALUtype, cu_adtype, cu_gatype, cu_shiftype, cu_sltype};
                tests_run++;
                if ((alu_o & msk) !== (val & msk) || {sel_in1, sel_in2} !== sel) begin
                    tests_failed++;
                    $display("FAIL %s cyc%0d alu/sel got %b/%b want %b/%b (mask %b)",
                             name, i, alu_o, {sel_in1, sel_in2}, val, sel, msk);
                end
            end
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (all_outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL %s in_reset outputs got %h want 000000", name, all_outs());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (all_outs() !== {1'b1, 21'd0}) begin
            tests_failed++;
            $display("FAIL %s after_release outputs got %h want %h", name, all_outs(), {1'b1, 21'd0});
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (all_outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL reset_hold outputs got %h want 000000", all_outs());
        end
        do_reset("reset");
    endtask

    task automatic test_alu_ops();
        run_instr(32'h40B50533, 1'b0, 0, "sub");
        run_instr(32'h4020D093, 1'b0, 0, "srai");
        run_instr(32'h0020B133, 1'b0, 0, "sltu");
        run_instr(32'h00B50533, 1'b0, 0, "add");
        run_instr(32'h000120B7, 1'b0, 0, "lui");
        run_instr(32'h00012097, 1'b0, 0, "auipc");
        run_instr(32'h008000EF, 1'b0, 0, "jal");
        run_instr(32'h000080E7, 1'b0, 0, "jalr");
    endtask

    task automatic test_branch();
        run_instr(32'h00208463, 1'b1, 0, "beq_taken");
        run_instr(32'h00208463, 1'b0, 0, "beq_not_taken");
    endtask

    task automatic test_mem();
        run_instr(32'h00052583, 1'b0, 3, "lw_wait3");
        run_instr(32'h00052583, 1'b0, 1, "lw_wait1");
        run_instr(32'h00052583, 1'b0, TO, "lw_ready_at_limit");
        run_instr(32'h00B52023, 1'b0, 2, "sw_wait2");
        run_instr(32'h00B52023, 1'b0, TO, "sw_ready_at_limit");
        run_instr(32'h00052583, 1'b0, 0, "lw_timeout");
        do_reset("after_lw_timeout");
        run_instr(32'h00B52023, 1'b0, 0, "sw_timeout");
        do_reset("after_sw_timeout");
    endtask

    task automatic test_illegal();
        logic [31:0] ins;
        run_instr(32'hFFFFFFFF, 1'b0, 0, "illegal_ffff");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr_valid = 1'b1;
            #1;
            tests_run++;
            if (obs_vec() !== pk(1,0,0,0,0,0,0,2'b00,2'b01)) begin
                tests_failed++;
                $display("FAIL trap_absorb cyc%0d got %b want %b", i, obs_vec(),
                         pk(1,0,0,0,0,0,0,2'b00,2'b01));
            end
        end
        instr_valid = 1'b0;
        do_reset("after_illegal");
        for (int n = 0; n < 4; n++) begin
            ins = $urandom;
            while (is_legal(ins[6:0])) ins[6:0] = 7'($urandom);
            run_instr(ins, 1'b0, 0, "illegal_rand");
            do_reset("after_illegal_rand");
        end
    endtask

    task automatic test_reset_mid_mem();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            instr_valid = (i == 0);
            instr       = 32'h00052583;
        end
        #1;
        tests_run++;
        if (mem_re !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_mem mem_re got %b want 1", mem_re);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (all_outs() !== 22'd0) begin
            tests_failed++;
            $display("FAIL async_reset outputs got %h want 000000", all_outs());
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (all_outs() !== {1'b1, 21'd0}) begin
            tests_failed++;
            $display("FAIL release_mid_mem outputs got %h want %h", all_outs(), {1'b1, 21'd0});
        end
        run_instr(32'h00052583, 1'b0, TO, "lw_after_reset");
    endtask

    task automatic test_random();
        logic [6:0]  legal_ops [9];
        logic [31:0] ins;
        int          ra;
        legal_ops = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR};
        for (int n = 0; n < 150; n++) begin
            ins      = $urandom;
            ins[6:0] = legal_ops[$urandom_range(0, 8)];
            ra       = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(1, 6));
            run_instr(ins, 1'($urandom_range(0, 1)), ra, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_instr(32'h00B52023, 1'b0, 1, "b2b_sw");
        run_instr(32'h00052583, 1'b0, 2, "b2b_lw");
        run_instr(32'h00208463, 1'b1, 0, "b2b_beq");
        run_instr(32'h40B50533, 1'b0, 0, "b2b_sub");
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_mem();
        test_illegal();
        test_reset_mid_mem();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm_rv32i.md
CTRL_FSM_RV32I -- requirements
Module: ctrl_fsm_rv32i

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning max cycles waiting for mem_ready before a timeout trap.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have ports instr_valid input 1 / instr input 32 / instr_ready output 1: fetch handshake; instruction word accepted on a cycle with both valid and ready high.
REQ-005 SHALL have ports br_taken input 1 (external comparator result) and mem_ready input 1 (data memory done).
REQ-006 SHALL have ALU control outputs cu_ALUtype 2, cu_adtype 1, cu_gatype 2, cu_shiftype 2, cu_sltype 1.
REQ-007 SHALL have datapath outputs sel_in1 2 (00 rs1, 01 PC, 10 zero), sel_in2 1 (0 rs2, 1 imm), wb_sel 2 (00 ALU, 01 mem, 10 PC+4), pc_sel 1 (0 PC+4, 1 ALU result).
REQ-008 SHALL have strobes reg_we, mem_re, mem_we, pc_we (each 1 bit) and status trap 1, trap_cause 2 (01 illegal, 10 mem timeout).

Function
REQ-009 States SHALL be FETCH, DECODE, EXEC, MEM, WB, TRAP; 3-bit state register.
REQ-010 FETCH: instr_ready=1; on instr_valid latch instr into an internal register and go to DECODE; else stay.
REQ-011 DECODE (exactly 1 cycle): opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111} -> TRAP with trap_cause=01; else EXEC.
REQ-012 Encodings SHALL be: ALUtype 00 adder, 01 gate, 10 shifter, 11 SLT; adtype 0 add, 1 sub; gatype 00 AND, 01 OR, 10 XOR; shiftype 00 SLL, 01 SRL, 10 SRA; sltype 0 signed, 1 unsigned.
REQ-013 OP/OP-IMM funct3 map: 000 adder (sub only when OP and funct7[5]=1), 001 SLL, 010 SLT signed, 011 SLT unsigned, 100 XOR, 101 SRL or SRA by funct7[5], 110 OR, 111 AND; sel_in1=00, sel_in2=0 for OP, 1 for OP-IMM.
REQ-014 LOAD/STORE/JALR: add, sel_in1=00, sel_in2=1; BRANCH/JAL/AUIPC: add, sel_in1=01, sel_in2=1; LUI: add, sel_in1=10, sel_in2=1.
REQ-015 ALU controls and selects SHALL be registered, updated on DECODE->EXEC transition, held constant through EXEC, MEM, WB.
REQ-016 EXEC (1 cycle): LOAD/STORE -> MEM; BRANCH -> FETCH with pc_we=1, pc_sel=br_taken; all others -> WB.
REQ-017 MEM: mem_re=1 (LOAD) or mem_we=1 (STORE) held every cycle until mem_ready; on mem_ready LOAD -> WB, STORE -> FETCH with pc_we=1, pc_sel=0.
REQ-018 MEM wait counter SHALL clear on MEM entry; if MEM_TIMEOUT cycles elapse without mem_ready -> TRAP, trap_cause=10, strobes deassert.
REQ-019 mem_ready in the same cycle the counter reaches MEM_TIMEOUT SHALL win (completion, no trap).
REQ-020 WB (1 cycle): reg_we=1 except for STORE/BRANCH; wb_sel=01 LOAD, 10 JAL/JALR, else 00; pc_we=1, pc_sel=1 for JAL/JALR, else 0; -> FETCH.
REQ-021 reg_we, mem_re, mem_we, pc_we SHALL be high only in the states listed above, each at most one instruction-commit per instruction.
REQ-022 TRAP SHALL be absorbing: trap=1, all strobes 0, instr_ready=0 until reset.
REQ-023 Instruction throughput: ALU-type 4 cycles from accept to next instr_ready, BRANCH 3, LOAD 5+wait, STORE 4+wait.

Reset
REQ-024 rst_n low SHALL immediately force state FETCH and all outputs 0, trap_cause 00, counter 0, regardless of current state (including mid-MEM).
REQ-025 First cycle after rst_n deasserts SHALL present instr_ready=1.

Verification
REQ-026 instr=0x40B50533 (sub) valid -> EXEC: ALUtype 00, adtype 1, sel_in2 0; WB: reg_we=1, wb_sel 00, pc_we=1.
REQ-027 instr=0x4020D093 (srai) -> ALUtype 10, shiftype 10, sel_in2 1; instr=0x0020B133 (sltu) -> ALUtype 11, sltype 1.
REQ-028 BRANCH 0x00208463 with br_taken=1 -> pc_we=1, pc_sel=1 in EXEC, reg_we never asserted, FETCH next cycle.
REQ-029 LOAD with mem_ready at wait cycle 3 -> mem_re high 3 cycles, WB wb_sel 01; LOAD with mem_ready never -> TRAP after 15 cycles, trap_cause 10.
REQ-030 instr=0xFFFFFFFF -> TRAP, trap_cause 01, instr_ready stays 0; rst_n pulse low during MEM -> outputs 0 asynchronously, FETCH after release.
